// File: rtl/anti_jitter_pkg.sv
// -----------------------------------------------------------------------------
// anti_jitter_pkg
// Shared types and sizing helpers for the anti_jitter_bank debouncer.
//   rpt_state_t : per-channel auto-repeat state (idle / hold delay / repeating)
//   cnt_width() : bit width of a counter that runs 0..max_count-1 (min 1 bit)
// -----------------------------------------------------------------------------
package anti_jitter_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/anti_jitter_ch.sv
// -----------------------------------------------------------------------------
// anti_jitter_ch
// One debounce channel: 2-flop synchroniser, stability counter, registered
// rise/fall pulses and the hold-then-repeat strobe generator.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sig_i      : raw asynchronous pad input
//   us_tick    : shared 1 us strobe (one cycle wide)
//   ms_tick    : shared 1 ms strobe (coincides with a us_tick)
//   sig_o      : debounced level
//   rise, fall : one-cycle pulses in the cycle sig_o first shows its new value
//   rpt        : one-cycle auto-repeat strobe (named rpt because "repeat" is a
//                reserved word in SystemVerilog)
// -----------------------------------------------------------------------------
module anti_jitter_ch
    import anti_jitter_pkg::*;
#(
    parameter int   JITTER_MAX = 10000,
    parameter logic INIT_BIT   = 1'b0,
    parameter int   HOLD_MS    = 500,
    parameter int   REPEAT_MS  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    input  logic us_tick,
    input  logic ms_tick,
    output logic sig_o,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int JIT_W  = cnt_width(JITTER_MAX);
    localparam int HOLD_W = cnt_width((HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS);

    localparam logic [JIT_W-1:0]  JIT_LAST    = JIT_W'(JITTER_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'((HOLD_MS > 0) ? HOLD_MS - 1 : 0);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);

    logic             sync_q;
    logic             s;
    logic [JIT_W-1:0] jit_cnt;
    logic             settle;
    logic             go_up;
    logic             go_down;

    rpt_state_t        state;
    rpt_state_t        state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nx;
    logic              rpt_nx;

    // Both stages reset to the channel's idle level so a pad that already
    // sits at INIT_BIT never produces an edge after reset release.
    // NOTE: flops use <= so each stage takes the pre-edge value of the one
    // before it; blocking assignments would merge the two stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= INIT_BIT;
            s      <= INIT_BIT;
        end else begin
            sync_q <= sig_i;
            s      <= sync_q;
        end
    end

    // The last tick of an uninterrupted disagreement commits the new level.
    assign settle  = us_tick && (s != sig_o) && (jit_cnt == JIT_LAST);
    assign go_up   = settle && s;
    assign go_down = settle && !s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jit_cnt <= '0;
            sig_o   <= INIT_BIT;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= go_up;
            fall <= go_down;
            // Agreement (including any glitch back) restarts the count.
            if ((s == sig_o) || settle) begin
                jit_cnt <= '0;
            end else if (us_tick) begin
                jit_cnt <= jit_cnt + 1'b1;
            end
            if (settle) begin
                sig_o <= s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RPT_IDLE;
            hold_cnt <= '0;
            rpt      <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            rpt      <= rpt_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        rpt_nx      = 1'b0;

        if (HOLD_MS == 0) begin
            state_nx = RPT_IDLE;
        end else if (go_down) begin
            // Release wins over a coincident ms_tick: no strobe on the way out.
            state_nx    = RPT_IDLE;
            hold_cnt_nx = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (go_up) begin
                        state_nx    = RPT_HOLD;
                        hold_cnt_nx = '0;
                    end
                end
                RPT_HOLD: begin
                    if (ms_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            rpt_nx      = 1'b1;
                            state_nx    = RPT_REPEAT;
                            hold_cnt_nx = '0;
                        end else begin
                            hold_cnt_nx = hold_cnt + 1'b1;
                        end
                    end
                end
                RPT_REPEAT: begin
                    // With REPEAT_MS == 0 the channel stays silent until release.
                    if (ms_tick && (REPEAT_MS > 0)) begin
                        if (hold_cnt == REPEAT_LAST) begin
                            rpt_nx      = 1'b1;
                            hold_cnt_nx = '0;
                        end else begin
                            hold_cnt_nx = hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx    = RPT_IDLE;
                    hold_cnt_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/anti_jitter_bank.sv
// -----------------------------------------------------------------------------
// anti_jitter_bank
// Multi-channel switch/button debouncer with edge pulses and auto-repeat.
// Holds the shared 1 us / 1 ms prescalers and one anti_jitter_ch per channel.
// Ports:
//   clk   : system clock (CLK_FREQ MHz)
//   rst   : asynchronous active-high reset
//   sig_i : [CHANNELS] raw asynchronous pad inputs
//   sig_o : [CHANNELS] debounced levels
//   rise  : [CHANNELS] one-cycle pulse on sig_o 0->1
//   fall  : [CHANNELS] one-cycle pulse on sig_o 1->0
//   rpt   : [CHANNELS] one-cycle auto-repeat strobe while sig_o stays 1
// -----------------------------------------------------------------------------
module anti_jitter_bank
    import anti_jitter_pkg::*;
#(
    parameter int                  CLK_FREQ   = 10,
    parameter int                  CHANNELS   = 16,
    parameter int                  JITTER_MAX = 10000,
    parameter logic [CHANNELS-1:0] INIT_VALUE = '0,
    parameter int                  HOLD_MS    = 500,
    parameter int                  REPEAT_MS  = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sig_i,
    output logic [CHANNELS-1:0] sig_o,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt
);

    localparam int US_PER_MS = 1000;
    localparam int US_W      = cnt_width(CLK_FREQ);
    localparam int MS_W      = cnt_width(US_PER_MS);

    localparam logic [US_W-1:0] US_LAST = US_W'(CLK_FREQ - 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);

    logic [US_W-1:0] us_cnt;
    logic [MS_W-1:0] ms_cnt;
    logic            us_tick;
    logic            ms_tick;

    // Ticks are decoded from the wrap value so they are high for exactly the
    // cycle in which the prescaler returns to zero.
    assign us_tick = (us_cnt == US_LAST);
    assign ms_tick = us_tick && (ms_cnt == MS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            us_cnt <= '0;
            ms_cnt <= '0;
        end else if (us_tick) begin
            us_cnt <= '0;
            ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
        end else begin
            us_cnt <= us_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        anti_jitter_ch #(
            .JITTER_MAX (JITTER_MAX),
            .INIT_BIT   (INIT_VALUE[i]),
            .HOLD_MS    (HOLD_MS),
            .REPEAT_MS  (REPEAT_MS)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig_i   (sig_i[i]),
            .us_tick (us_tick),
            .ms_tick (ms_tick),
            .sig_o   (sig_o[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .rpt     (rpt[i])
        );
    end

endmodule

// File: tb/tb_anti_jitter_bank.sv
// -----------------------------------------------------------------------------
// tb_anti_jitter_bank
// Self-checking bench for anti_jitter_bank (CLK_FREQ=10, CHANNELS=4,
// JITTER_MAX=4, INIT_VALUE=4'b1000, HOLD_MS=2, REPEAT_MS=1).
// A timeline reference model compares all outputs every cycle; a vector table
// and directed sequences cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_anti_jitter_bank;

    localparam int            CF   = 10;
    localparam int            CH   = 4;
    localparam int            JM   = 4;
    localparam int            HOLD = 2;
    localparam int            REP  = 1;
    localparam int            MS   = CF * 1000;
    localparam logic [CH-1:0] INIT = 4'b1000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] sig_i = INIT;
    logic [CH-1:0] sig_o;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] rpt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    anti_jitter_bank #(
        .CLK_FREQ   (CF),
        .CHANNELS   (CH),
        .JITTER_MAX (JM),
        .INIT_VALUE (INIT),
        .HOLD_MS    (HOLD),
        .REPEAT_MS  (REP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sig_i (sig_i),
        .sig_o (sig_o),
        .rise  (rise),
        .fall  (fall),
        .rpt   (rpt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Time is the index k of the clock edge since reset
    // release; us ticks land on edges k%CF==0 and ms ticks on k%MS==0.
    // A level is accepted once JM tick edges fall inside an unbroken stretch
    // of disagreement; repeats fire on the HOLD-th ms tick after the rise
    // edge and every REP ms ticks after that.
    // ------------------------------------------------------------------
    logic [CH-1:0] m_s1, m_s2, m_out, e_rise, e_fall, e_rep;
    int            m_k;
    int            mm_start [CH];
    bit            armed    [CH];
    int            rise_k   [CH];

    task automatic model_reset();
        m_s1 = INIT; m_s2 = INIT; m_out = INIT;
        e_rise = '0; e_fall = '0; e_rep = '0;
        m_k = 0;
        for (int c = 0; c < CH; c++) begin
            mm_start[c] = -1; armed[c] = 1'b0; rise_k[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] s;
        bit            at_us, at_ms, flipped;
        int            n;
        m_k++;
        s     = m_s2;
        at_us = (m_k % CF) == 0;
        at_ms = (m_k % MS) == 0;
        e_rise = '0; e_fall = '0; e_rep = '0;
        for (int c = 0; c < CH; c++) begin
            flipped = 1'b0;
            if (s[c] == m_out[c]) begin
                mm_start[c] = -1;
            end else begin
                if (mm_start[c] < 0) mm_start[c] = m_k;
                if (at_us && (m_k / CF - (mm_start[c] - 1) / CF) == JM) begin
                    flipped     = 1'b1;
                    m_out[c]    = s[c];
                    mm_start[c] = -1;
                    if (s[c]) begin
                        e_rise[c] = 1'b1; armed[c] = 1'b1; rise_k[c] = m_k;
                    end else begin
                        e_fall[c] = 1'b1; armed[c] = 1'b0;
                    end
                end
            end
            if (!flipped && armed[c] && at_ms && HOLD > 0) begin
                n = m_k / MS - rise_k[c] / MS;
                if (n == HOLD || (REP > 0 && n > HOLD && (n - HOLD) % REP == 0))
                    e_rep[c] = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = sig_i;
    endtask

    // Compare on the falling edge, then predict the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            check("scoreboard_in_reset", {sig_o, rise, fall, rpt}, {INIT, 12'h000});
        end else begin
            check("scoreboard", {sig_o, rise, fall, rpt}, {m_out, e_rise, e_fall, e_rep});
            model_step();
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change 2 time units after a rising edge,
    // which is also where outputs of that edge are observed.
    // ------------------------------------------------------------------
    typedef struct {
        logic [CH-1:0] sig;
        int            cycles;
        logic [CH-1:0] exp_sig_o;
        int            exp_rise;
        int            exp_fall;
        int            exp_rep;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Steps until the chosen pulse is seen on channel ch; n = cycles waited,
    // bound+1 when it never arrived.
    task automatic wait_pulse(input int ch, input bit want_rise, input int bound, output int n);
        n = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (want_rise ? rise[ch] : fall[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   r, f, p, n, ev;
        int   rep_q [$];

        vecs[0] = '{4'b1000, 1000, 4'b1000, 0, 0, 0};
        vecs[1] = '{4'b1001,  100, 4'b1001, 1, 0, 0};
        vecs[2] = '{4'b0001,  100, 4'b0001, 0, 1, 0};
        vecs[3] = '{4'b0000,  100, 4'b0000, 0, 1, 0};
        vecs[4] = '{4'b0110,  100, 4'b0110, 2, 0, 0};
        vecs[5] = '{4'b1000,  100, 4'b1000, 1, 2, 0};

        #1 rst = 1'b1;
        repeat (3) step();
        check("reset_sig_o", sig_o, INIT);
        check("reset_pulses", {rise, fall, rpt}, 0);
        rst = 1'b0;

        // Level sequence table: pulse counts per step and the settled level.
        for (int i = 0; i < 6; i++) begin
            sig_i = vecs[i].sig;
            r = 0; f = 0; p = 0;
            repeat (vecs[i].cycles) begin
                step();
                r += $countones(rise);
                f += $countones(fall);
                p += $countones(rpt);
            end
            check($sformatf("vec%0d_sig_o", i), sig_o, vecs[i].exp_sig_o);
            check($sformatf("vec%0d_rise_count", i), r, vecs[i].exp_rise);
            check($sformatf("vec%0d_fall_count", i), f, vecs[i].exp_fall);
            check($sformatf("vec%0d_repeat_count", i), p, vecs[i].exp_rep);
        end

        // Simultaneous fall on channel 3 and rise on channel 0.
        sig_i = 4'b0001;
        n = 0;
        while ((rise | fall) == '0 && n < 100) begin
            step();
            n++;
        end
        check("t5_rise_same_cycle", rise, 4'b0001);
        check("t5_fall_same_cycle", fall, 4'b1000);
        sig_i = 4'b0000;
        repeat (100) step();

        // Latency of a clean 0->1 on channel 0.
        sig_i = 4'b0001;
        wait_pulse(0, 1'b1, 100, n);
        check("t2_latency_33_to_43", (n >= 33 && n <= 43), 1);
        check("t2_sig_o_at_rise", sig_o, 4'b0001);
        step();
        check("t2_rise_single_cycle", rise, 4'b0000);
        sig_i = 4'b0000;
        repeat (100) step();

        // Channel 1 toggled every 2 us never settles.
        ev = 0;
        for (int t = 0; t < 500; t++) begin
            if (t % 20 == 0) sig_i[1] = ~sig_i[1];
            step();
            ev += int'(sig_o[1]) + int'(rise[1]) + int'(fall[1]);
        end
        check("t3_glitch_no_activity", ev, 0);
        sig_i = 4'b0000;
        repeat (60) step();

        // Channel 2 held: hold delay then periodic repeat, silence after release.
        sig_i = 4'b0100;
        wait_pulse(2, 1'b1, 100, n);
        check("t4_rise_seen", (n <= 100), 1);
        for (int c = 1; c <= 45000; c++) begin
            step();
            if (rpt[2]) rep_q.push_back(c);
        end
        check("t4_repeat_count_ge3", (rep_q.size() >= 3), 1);
        check("t4_first_repeat_window",
              (rep_q.size() > 0) && (rep_q[0] >= 10001) && (rep_q[0] <= 20000), 1);
        for (int i = 1; i < rep_q.size(); i++)
            check($sformatf("t4_repeat_period_%0d", i), rep_q[i] - rep_q[i-1], MS);
        sig_i = 4'b0000;
        wait_pulse(2, 1'b0, 100, n);
        check("t4_fall_seen", (n <= 100), 1);
        check("t4_no_repeat_on_fall", rpt[2], 1'b0);
        p = 0;
        repeat (10200) begin
            step();
            p += int'(rpt[2]);
        end
        check("t4_silent_after_release", p, 0);

        // Asynchronous reset in the middle of a hold on channel 0.
        sig_i = 4'b0001;
        wait_pulse(0, 1'b1, 100, n);
        check("t6_rise_seen", (n <= 100), 1);
        repeat (5000) step();
        rst = 1'b1;
        #1;
        check("t6_async_sig_o", sig_o, INIT);
        check("t6_async_pulses", {rise, fall, rpt}, 0);
        repeat (3) step();
        rst = 1'b0;
        p = 0;
        n = 101;
        for (int i = 1; i <= 100; i++) begin
            step();
            p += int'(rpt[0]);
            if (rise[0]) begin
                n = i;
                break;
            end
        end
        check("t6_fresh_rise_seen", (n <= 100), 1);
        n = 25001;
        for (int i = 1; i <= 25000; i++) begin
            step();
            if (rpt[0]) begin
                n = i;
                break;
            end
        end
        check("t6_no_early_repeat", p, 0);
        check("t6_repeat_2ms_after_rise", (n >= 10001 && n <= 20000), 1);

        // Randomised levels and hold times, judged by the reference model.
        repeat (60) begin
            sig_i = CH'($urandom);
            repeat ($urandom_range(5, 80)) step();
        end
        repeat (100) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
